uart_core: RTL and testbench

UART engine for the CPU's memory-mapped peripheral block: a 16× baud-tick generator, an 8N1 receiver and an 8N1 transmitter. The peripheral register file drives `tx_data`/`tx_en` and watches `tx_status`, `rx_data` and `rx_status`. Serial pins go straight to the board's UART.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_core_if.sv | 17 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_rx.sv | 102 ++++++++++
 rtl/uart_tx.sv | 103 ++++++++++
 rtl/uart_core.sv | 47 ++++
 tb/tb_uart_core.sv | 249 ++++++++++++++++++++++++
 7 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and the state type shared by the UART receiver and
// transmitter.
//   OVERSAMPLE   ticks per serial bit
//   DATA_BITS    data bits per frame
//   MID_SAMPLE   ticks from the start edge to the middle of the start bit
//   uart_state_t frame phase, used by both RX and TX
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_core_if.sv
// uart_core_if: register-file side of the UART.
//   tx_data   byte to send
//   tx_en     send request, level-sampled on each baud tick
//   tx_status 1 = transmitter idle and ready
//   rx_data   last good received byte
//   rx_status byte-valid flag, high for one brclk16 period
// master = register file, slave = uart_core.
interface uart_core_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic [7:0] rx_data;
  logic       rx_status;

  modport master (output tx_data, tx_en, input tx_status, rx_data, rx_status);
  modport slave  (input tx_data, tx_en, output tx_status, rx_data, rx_status);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversampling tick generator.
//   clk, reset   system clock, asynchronous active-low reset
//   brclk16_o    50% duty square wave, period 2*(BRCLK_HALF+1) clk
//   tick_o       one-clk pulse on the clk edge where brclk16 rises
module uart_baud_gen #(
  parameter int BRCLK_HALF = 325
) (
  input  logic clk,
  input  logic reset,
  output logic brclk16_o,
  output logic tick_o
);

  localparam int CW = (BRCLK_HALF > 0) ? $clog2(BRCLK_HALF + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          brclk_q, brclk_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(BRCLK_HALF));

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    brclk_d = wrap ? ~brclk_q : brclk_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      brclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      brclk_q <= brclk_d;
    end
  end

  assign brclk16_o = brclk_q;
  // The RX/TX logic runs on clk with this enable instead of on brclk16
  // itself; their registers change on exactly the edge where brclk16 rises.
  assign tick_o    = wrap & ~brclk_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampled.
//   clk, reset  system clock, asynchronous active-low reset
//   tick_i      baud tick enable (rising edge of brclk16)
//   rx_i        serial input, idle high, asynchronous
//   data_o      last good byte
//   valid_o     high for exactly one tick after a good stop bit
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  uart_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sync1_q, sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check mid start bit; a high line here was only a glitch.
        if (cnt_q == 4'(MID_SAMPLE - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATA: begin
        if (cnt_q == 4'(OVERSAMPLE - 1)) begin
          cnt_d   = '0;
          // LSB arrives first, so shift right and insert at the top.
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STOP: begin
        if (cnt_q == 4'(OVERSAMPLE - 1)) begin
          state_d = IDLE;
          // A low stop bit is a framing error: keep the previous byte.
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else if (tick_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter, 16 ticks per bit.
//   clk, reset  system clock, asynchronous active-low reset
//   tick_i      baud tick enable (rising edge of brclk16)
//   data_i      byte to send, latched when a frame starts
//   en_i        send request, sampled on ticks while idle
//   tx_o        serial output, idle high
//   status_o    1 = idle and ready, 0 = frame in progress
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic [7:0] data_i,
  input  logic       en_i,
  output logic       tx_o,
  output logic       status_o
);

  uart_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        status_q, status_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          shift_d  = data_i;
          cnt_d    = '0;
          tx_d     = 1'b0;
          status_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == 4'(OVERSAMPLE - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATA: begin
        if (cnt_q == 4'(OVERSAMPLE - 1)) begin
          cnt_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            // Next bit on the line is the one about to reach position 0.
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STOP: begin
        if (cnt_q == 4'(OVERSAMPLE - 1)) begin
          status_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
    end else if (tick_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      status_q <= status_d;
    end
  end

  assign tx_o     = tx_q;
  assign status_o = status_q;

endmodule

// File: rtl/uart_core.sv
// uart_core: UART engine for the memory-mapped peripheral block.
//   clk, reset  system clock, asynchronous active-low reset
//   rx          serial in (idle high, asynchronous)
//   tx          serial out (idle high)
//   brclk16     16x oversampling tick clock, exported for observation
//   bus         register-file side (tx_data/tx_en/tx_status/rx_data/rx_status)
// RX and TX are independent and share only the baud tick.
module uart_core #(
  parameter int BRCLK_HALF = 325
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        brclk16,
  uart_core_if.slave  bus
);

  logic tick;

  uart_baud_gen #(.BRCLK_HALF(BRCLK_HALF)) u_baud (
    .clk       (clk),
    .reset     (reset),
    .brclk16_o (brclk16),
    .tick_o    (tick)
  );

  uart_rx u_rx (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick),
    .rx_i    (rx),
    .data_o  (bus.rx_data),
    .valid_o (bus.rx_status)
  );

  uart_tx u_tx (
    .clk      (clk),
    .reset    (reset),
    .tick_i   (tick),
    .data_i   (bus.tx_data),
    .en_i     (bus.tx_en),
    .tx_o     (tx),
    .status_o (bus.tx_status)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core with a shortened baud
// divider. Expected serial waveforms and received bytes come from the 8N1
// frame rules (start 0, LSB first, stop 1, 16 ticks per bit).
module tb_uart_core;

  localparam int HALF = 2;
  localparam int TICK = 2 * (HALF + 1);   // clk per tick
  localparam int BITC = 16 * TICK;        // clk per serial bit

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic rx, tx, brclk16;

  uart_core_if bus();

  assign rx = loop_en ? tx : rx_drv;

  uart_core #(.BRCLK_HALF(HALF)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .tx      (tx),
    .brclk16 (brclk16),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Received-byte monitor: one entry per rx_status rising edge, and each
  // pulse must last exactly one tick.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  initial begin
    int  pulse_w;
    logic stat_prev;
    pulse_w = 0;
    stat_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pulse_w = 0;
        stat_prev = 1'b0;
      end else begin
        if (bus.rx_status === 1'b1) begin
          if (!stat_prev) got_q.push_back(bus.rx_data);
          pulse_w++;
        end else if (stat_prev) begin
          check_val("rx_pulse_width", 32'(pulse_w), 32'(TICK));
          pulse_w = 0;
        end
        stat_prev = (bus.rx_status === 1'b1);
      end
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_status(input logic lvl, input int limit, output int unsigned t, output bit ok);
    int n = 0;
    while (bus.tx_status !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.tx_status === lvl);
    if (!ok) check_val("tx_status_timeout", 32'(bus.tx_status), 32'(lvl));
    t = cyc;
  endtask

  // Sends one byte and checks every bit at its centre plus the busy window.
  task automatic tx_frame(input logic [7:0] d);
    int unsigned t0;
    bit ok;
    logic eb;
    bus.tx_data = d;
    bus.tx_en = 1'b1;
    wait_status(1'b0, 4 * TICK, t0, ok);
    bus.tx_en = 1'b0;
    bus.tx_data = 8'($urandom);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        wait_until(t0 + 32'((16 * i + 8) * TICK));
        eb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
        check_val($sformatf("tx_bit%0d_%02h", i, d), 32'(tx), 32'(eb));
      end
      wait_until(t0 + 32'(160 * TICK) - 1);
      check_val("tx_busy_last", 32'(bus.tx_status), 32'd0);
      wait_until(t0 + 32'(160 * TICK));
      check_val("tx_ready_after", 32'(bus.tx_status), 32'd1);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    repeat ($urandom_range(0, TICK - 1)) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drv = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : d[i-1];
      repeat (BITC) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (4 * TICK) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_val({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, t1, t2;
    bit ok;
    logic [7:0] d_tx, d_rx, last_good;

    bus.tx_data = 8'h00;
    bus.tx_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", 32'(tx), 32'd1);
    check_val("rst_tx_status", 32'(bus.tx_status), 32'd1);
    check_val("rst_rx_status", 32'(bus.rx_status), 32'd0);
    check_val("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check_val("rst_brclk16", 32'(brclk16), 32'd0);

    // brclk16 first toggles HALF+1 clk after release, then every HALF+1
    reset = 1'b1;
    c0 = cyc;
    wait_until(c0 + HALF);
    check_val("brclk_before_first", 32'(brclk16), 32'd0);
    wait_until(c0 + HALF + 1);
    check_val("brclk_first", 32'(brclk16), 32'd1);
    wait_until(c0 + 2 * HALF + 1);
    check_val("brclk_hold", 32'(brclk16), 32'd1);
    wait_until(c0 + 2 * HALF + 2);
    check_val("brclk_second", 32'(brclk16), 32'd0);

    // Transmit A5, then confirm no second frame
    tx_frame(8'hA5);
    repeat (20 * TICK) @(negedge clk);
    check_val("tx_no_refire_status", 32'(bus.tx_status), 32'd1);
    check_val("tx_no_refire_line", 32'(tx), 32'd1);

    // Receive 3C
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    check_rx("rx_3c");
    check_val("rx_data_3c", 32'(bus.rx_data), 32'h3C);
    last_good = 8'h3C;

    // Two-tick glitch on an idle line
    rx_drv = 1'b0;
    repeat (2 * TICK) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30 * TICK) @(negedge clk);
    check_rx("glitch");

    // Framing error: FF with a low stop bit
    send_rx(8'hFF, 1'b0);
    repeat (8 * TICK) @(negedge clk);
    check_rx("framing");
    check_val("rx_data_kept", 32'(bus.rx_data), 32'(last_good));

    // Random simultaneous send and receive
    for (int k = 0; k < 4; k++) begin
      d_tx = 8'($urandom);
      d_rx = 8'($urandom);
      exp_q.push_back(d_rx);
      fork
        tx_frame(d_tx);
        send_rx(d_rx, 1'b1);
      join
      repeat (4 * TICK) @(negedge clk);
      check_rx($sformatf("rx_rand%0d", k));
      check_val("rx_data_rand", 32'(bus.rx_data), 32'(d_rx));
    end

    // Loopback, 00 then 7E back-to-back
    loop_en = 1'b1;
    repeat (4 * TICK) @(negedge clk);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h7E);
    bus.tx_data = 8'h00;
    bus.tx_en = 1'b1;
    wait_status(1'b0, 4 * TICK, t1, ok);
    bus.tx_en = 1'b0;
    repeat (20 * TICK) @(negedge clk);
    bus.tx_data = 8'h7E;
    bus.tx_en = 1'b1;
    wait_status(1'b1, 170 * TICK, t1, ok);
    wait_status(1'b0, 4 * TICK, t2, ok);
    bus.tx_en = 1'b0;
    check_val("b2b_gap", 32'((t2 - t1) <= TICK), 32'd1);
    wait_status(1'b1, 170 * TICK, t1, ok);
    repeat (8 * TICK) @(negedge clk);
    check_rx("loopback");
    check_val("rx_data_loop", 32'(bus.rx_data), 32'h7E);

    // Reset during data bit 4 of a loopback frame
    bus.tx_data = 8'hE0;
    bus.tx_en = 1'b1;
    wait_status(1'b0, 4 * TICK, t1, ok);
    bus.tx_en = 1'b0;
    wait_until(t1 + 32'((16 * 5 + 8) * TICK));
    check_val("tx_bit4_pre", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    check_val("mid_rst_tx", 32'(tx), 32'd1);
    check_val("mid_rst_tx_status", 32'(bus.tx_status), 32'd1);
    check_val("mid_rst_rx_status", 32'(bus.rx_status), 32'd0);
    check_val("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check_val("mid_rst_brclk16", 32'(brclk16), 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (4 * TICK) @(negedge clk);
    exp_q.push_back(8'h55);
    tx_frame(8'h55);
    repeat (8 * TICK) @(negedge clk);
    check_rx("post_reset");
    check_val("rx_data_55", 32'(bus.rx_data), 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
